// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift register command sequencer.
package shift_seq_pkg;

  // Command opcodes as they appear on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_SHIFT  = 2'b01,
    OP_ROTATE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StClr  = 2'b10,
    StResp = 2'b11
  } state_e;

  // Shift direction values for the register dir pin.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter holding the number of shift edges still to issue.
module shift_seq_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_d, count_q;

  // Load has priority over decrement; caller keeps dec low at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving a bidirectional shift register one edge at a time.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned MSB = 8,
  parameter int unsigned CW  = $clog2(MSB) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic           cmd_dir,
  input  logic [CW-1:0]  cmd_count,
  input  logic           cmd_fill,
  input  logic [MSB-1:0] cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [MSB-1:0] rsp_data,
  output logic           rsp_carry,
  output logic           sr_d,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           sr_circular,
  output logic           sr_rstn,
  output logic           sr_carry_in,
  input  logic [MSB-1:0] sr_out,
  input  logic           sr_carry_out
);

  state_e         state_d, state_q;
  op_e            op_d, op_q;
  logic           dir_d, dir_q;
  logic           fill_d, fill_q;
  logic [MSB-1:0] data_d, data_q;
  logic           rsp_carry_d, rsp_carry_q;

  logic           cnt_load;
  logic           cnt_dec;
  logic [CW-1:0]  cnt_load_val;
  logic [CW-1:0]  cnt;
  logic           cnt_zero;
  logic           cnt_last;
  logic [CW-1:0]  count_sat;
  op_e            cmd_op_e;

  assign cmd_op_e  = op_e'(cmd_op);
  // Counts beyond the register width are clamped to a full-width pass.
  assign count_sat = (cmd_count > CW'(MSB)) ? CW'(MSB) : cmd_count;

  // Remaining-edge count for the command being executed.
  always_comb begin
    unique case (cmd_op_e)
      OP_LOAD:  cnt_load_val = CW'(MSB);
      OP_CLEAR: cnt_load_val = '0;
      default:  cnt_load_val = count_sat;
    endcase
  end

  assign cnt_load = (state_q == StIdle) && cmd_valid;
  assign cnt_dec  = (state_q == StRun) && !cnt_zero;
  assign cnt_last = (cnt == CW'(1));

  shift_seq_counter #(
    .CW(CW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // Next-state logic and command latching.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dir_d       = dir_q;
    fill_d      = fill_q;
    data_d      = data_q;
    rsp_carry_d = rsp_carry_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = cmd_op_e;
          dir_d       = cmd_dir;
          fill_d      = cmd_fill;
          data_d      = cmd_data;
          rsp_carry_d = 1'b0;
          if (cmd_op_e == OP_CLEAR) begin
            state_d = StClr;
          end else if (cnt_load_val == '0) begin
            state_d = StResp;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // LOAD feeds the word LSB first; consume one bit per edge.
        if (op_q == OP_LOAD) begin
          data_d = data_q >> 1;
        end
        if (cnt_last || cnt_zero) begin
          rsp_carry_d = sr_carry_out;
          state_d     = StResp;
        end
      end
      StClr: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control-pin and response decode from the current state.
  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    sr_en       = 1'b0;
    sr_d        = 1'b0;
    sr_dir      = DIR_RIGHT;
    sr_circular = 1'b0;
    sr_carry_in = 1'b0;
    sr_rstn     = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
      end
      StRun: begin
        sr_en = 1'b1;
        unique case (op_q)
          OP_LOAD: begin
            sr_d = data_q[0];
          end
          OP_SHIFT: begin
            sr_dir      = dir_q;
            sr_d        = fill_q;
            sr_carry_in = fill_q;
          end
          OP_ROTATE: begin
            sr_dir      = dir_q;
            sr_circular = 1'b1;
          end
          default: begin
          end
        endcase
      end
      StClr: begin
        sr_rstn = 1'b0;
      end
      StResp: begin
        rsp_valid = 1'b1;
        // Register is idle here, so its contents are stable for the whole response.
        rsp_data  = (op_q == OP_CLEAR) ? '0 : sr_out;
      end
      default: begin
      end
    endcase
  end

  assign rsp_carry = rsp_carry_q;

  // State and latched-command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OP_LOAD;
      dir_q       <= DIR_RIGHT;
      fill_q      <= 1'b0;
      data_q      <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dir_q       <= dir_d;
      fill_q      <= fill_d;
      data_q      <= data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: attaches a behavioural shift register and compares each
// response against an arithmetic model of the command set.
module tb_shift_seq_ctrl;

  localparam int unsigned MSB = 8;
  localparam int unsigned CW  = $clog2(MSB) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic           cmd_dir;
  logic [CW-1:0]  cmd_count;
  logic           cmd_fill;
  logic [MSB-1:0] cmd_data;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [MSB-1:0] rsp_data;
  logic           rsp_carry;
  logic           sr_d, sr_en, sr_dir, sr_circular, sr_rstn, sr_carry_in;
  logic [MSB-1:0] sr_out;
  logic           sr_carry_out;
  logic [MSB-1:0] sr_q;

  int checks = 0;
  int errors = 0;
  int ref_val = 0;
  int en_edges = 0;
  int rstn_edges = 0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(
    .MSB(MSB),
    .CW (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dir      (cmd_dir),
    .cmd_count    (cmd_count),
    .cmd_fill     (cmd_fill),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_carry    (rsp_carry),
    .sr_d         (sr_d),
    .sr_en        (sr_en),
    .sr_dir       (sr_dir),
    .sr_circular  (sr_circular),
    .sr_rstn      (sr_rstn),
    .sr_carry_in  (sr_carry_in),
    .sr_out       (sr_out),
    .sr_carry_out (sr_carry_out)
  );

  // Behavioural shift register; carry_out is the bit that would leave on this edge.
  assign sr_out       = sr_q;
  assign sr_carry_out = sr_dir ? sr_q[MSB-1] : sr_q[0];
  always @(posedge clk) begin
    if (!sr_rstn) begin
      sr_q <= '0;
    end else if (sr_en) begin
      if (!sr_dir) sr_q <= {(sr_circular ? sr_q[0] : sr_d), sr_q[MSB-1:1]};
      else         sr_q <= {sr_q[MSB-2:0], (sr_circular ? sr_q[MSB-1] : sr_carry_in)};
    end
  end

  // Running tallies of shift edges and register-reset edges.
  always @(posedge clk) begin
    if (sr_en)    en_edges   <= en_edges + 1;
    if (!sr_rstn) rstn_edges <= rstn_edges + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Command semantics expressed arithmetically on the whole word.
  task automatic ref_model(input int op, input int dir, input int cnt, input int fill,
                           input int data, output int res, output int carry,
                           output int lat, output int shifts);
    int v, m, n, fb;
    v = ref_val;
    m = (1 << MSB) - 1;
    res = v; carry = 0; lat = 0; shifts = 0;
    case (op)
      0: begin
        res = data & m; carry = (v >> (MSB - 1)) & 1; lat = MSB; shifts = MSB;
      end
      3: begin
        res = 0; carry = 0; lat = 1; shifts = 0;
      end
      default: begin
        n = (cnt > int'(MSB)) ? int'(MSB) : cnt;
        lat = n; shifts = n;
        if (n != 0) begin
          fb = fill ? ((1 << n) - 1) : 0;
          if (dir == 0) begin
            carry = (v >> (n - 1)) & 1;
            if (op == 2) res = ((v >> n) | (v << (int'(MSB) - n))) & m;
            else         res = (v >> n) | (fb << (int'(MSB) - n));
          end else begin
            carry = (v >> (int'(MSB) - n)) & 1;
            if (op == 2) res = ((v << n) | (v >> (int'(MSB) - n))) & m;
            else         res = ((v << n) & m) | fb;
          end
        end
      end
    endcase
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({pfx, "_rsp_data"}, 32'(rsp_data), 0);
    check({pfx, "_rsp_carry"}, 32'(rsp_carry), 0);
    check({pfx, "_sr_ctl"}, 32'({sr_en, sr_d, sr_dir, sr_circular, sr_carry_in, sr_rstn}), 1);
  endtask

  task automatic do_cmd(input int op, input int dir, input int cnt, input int fill,
                        input int data, input int hold, output int got_d, output int got_c);
    int exp_d, exp_c, lat, shifts, en0, rs0, cyc;
    ref_model(op, dir, cnt, fill, data, exp_d, exp_c, lat, shifts);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_dir   = dir[0];
    cmd_count = cnt[CW-1:0];
    cmd_fill  = fill[0];
    cmd_data  = data[MSB-1:0];
    en0 = en_edges;
    rs0 = rstn_edges;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rsp_latency", cyc, lat);
    check("rsp_valid", 32'(rsp_valid), 1);
    check("cmd_ready_busy", 32'(cmd_ready), 0);
    check("rsp_data", 32'(rsp_data), exp_d);
    check("rsp_carry", 32'(rsp_carry), exp_c);
    check("shift_edges", en_edges - en0, shifts);
    check("rstn_edges", rstn_edges - rs0, (op == 3) ? 1 : 0);
    got_d = 32'(rsp_data);
    got_c = 32'(rsp_carry);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", 32'(rsp_data), exp_d);
      check("hold_ready", 32'(cmd_ready), 0);
    end
    check("hold_no_shift", en_edges - en0, shifts);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 0);
    check("ready_back", 32'(cmd_ready), 1);
    ref_val = exp_d;
  endtask

  initial begin
    int d, c, en0, pulses;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_dir = 1'b0; cmd_count = '0; cmd_fill = 1'b0; cmd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Bring the attached register to a known value.
    do_cmd(3, 0, 0, 0, 0, 0, d, c);
    check("clear0_data", d, 'h00);

    do_cmd(0, 0, 0, 0, 'hA5, 0, d, c);
    check("load_a5", d, 'hA5);
    do_cmd(2, 0, 3, 0, 0, 0, d, c);
    check("rot_r3_data", d, 'hB4);
    check("rot_r3_carry", c, 1);

    do_cmd(0, 0, 0, 0, 'h81, 0, d, c);
    do_cmd(1, 1, 2, 0, 0, 0, d, c);
    check("shl2_data", d, 'h04);
    check("shl2_carry", c, 0);
    do_cmd(1, 0, 8, 1, 0, 0, d, c);
    check("shr8_fill", d, 'hFF);

    do_cmd(1, 1, 0, 1, 0, 0, d, c);
    check("shift0_data", d, 'hFF);
    check("shift0_carry", c, 0);
    do_cmd(3, 0, 0, 0, 0, 0, d, c);
    check("clear_data", d, 'h00);

    do_cmd(0, 0, 0, 0, 'h5A, 5, d, c);
    do_cmd(1, 1, 13, 1, 0, 2, d, c);
    check("sat_shl_fill", d, 'hFF);

    // Reset in the middle of a LOAD.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h3C;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_en", 32'(sr_en), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    en0 = en_edges;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) pulses++;
    end
    check("midrst_no_rsp", pulses, 0);
    check("midrst_no_shift", en_edges - en0, 0);

    do_cmd(3, 0, 0, 0, 0, 0, d, c);
    do_cmd(0, 0, 0, 0, 'hC3, 0, d, c);
    check("resync_load", d, 'hC3);

    for (int i = 0; i < 40; i++) begin
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), d, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the bidirectional shift register (MSB-bit, serial d input, dir/circular/en controls, active-low rstn). It accepts one command at a time over a valid/ready interface: LOAD a word serially, SHIFT or ROTATE by N positions, or CLEAR. It drives the register's control pins cycle by cycle and returns the final register contents plus the last carry over a valid/ready response interface. It sits between the bus-side command logic and the shift register datapath.

Parameters:
MSB, 8, shift register width (must match the attached register)
CW, $clog2(MSB)+1, width of the shift count field

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 LOAD, 01 SHIFT, 10 ROTATE, 11 CLEAR
cmd_dir  in  1  0 = right shift, 1 = left shift (SHIFT/ROTATE only)
cmd_count  in  CW  shift count for SHIFT/ROTATE, 0..MSB
cmd_fill  in  1  serial fill bit for SHIFT
cmd_data  in  MSB  word for LOAD
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  MSB  register contents after the command
rsp_carry  out  1  sr_carry_out sampled at the last shift edge (0 if no shift)
sr_d  out  1  to register d
sr_en  out  1  to register en
sr_dir  out  1  to register dir
sr_circular  out  1  to register circular
sr_rstn  out  1  to register rstn (active-low)
sr_carry_in  out  1  to register carry_in
sr_out  in  MSB  from register out
sr_carry_out  in  1  from register carry_out

Behaviour:
- Register contract: each posedge with en=1 shifts once. With dir=0, d enters out[MSB-1]. With circular=1, the exiting bit re-enters. carry_out is the bit shifted out.
- FSM states: IDLE, RUN, CLR, RESP. cmd_ready = (state==IDLE).
- Reset (rst=1 at a posedge, including mid-command): state=IDLE, rsp_valid=0, rsp_data=0, rsp_carry=0, sr_en=0, sr_d=0, sr_dir=0, sr_circular=0, sr_carry_in=0, sr_rstn=1, counter=0. An in-flight command is dropped with no response.
- IDLE, handshake at edge E0: latch op/dir/fill/data and load the remaining-count register (LOAD uses MSB; SHIFT/ROTATE use cmd_count).
  - CLEAR goes to CLR.
  - Count 0 goes directly to RESP.
  - Otherwise goes to RUN.
- RUN: sr_en=1 combinationally from state.
  - LOAD: dir=0, circular=0, sr_d = data[k] on the k-th cycle (LSB first), so out==cmd_data after MSB edges.
  - SHIFT: dir=cmd_dir, circular=0, sr_d=sr_carry_in=fill.
  - ROTATE: dir=cmd_dir, circular=1.
  - Counter decrements each edge. On the edge where the counter reaches 0, capture sr_carry_out into rsp_carry and go to RESP.
- Latency: N shift edges follow E0. rsp_valid is high in the cycle after the N-th shift edge, and rsp_data = sr_out is sampled on that cycle's entry (registered at the first RESP edge). The total from accept to rsp_valid is N+1 cycles.
- CLR: sr_rstn=0 for exactly one cycle, then RESP with rsp_data=0 and rsp_carry=0.
- RESP: rsp_valid is held with stable data until rsp_valid&&rsp_ready, then IDLE. No new command is accepted while in RESP.
- cmd_count > MSB saturates to MSB.
- sr_en=0 outside RUN. Controls are don't-care but are driven to their reset values.

Decomposition:
- Package shift_seq_pkg: op encodings (OP_LOAD, OP_SHIFT, OP_ROTATE, OP_CLEAR), FSM state encoding, DIR_RIGHT/DIR_LEFT constants.
- One natural sub-module: shift_seq_counter, a loadable down-counter with a zero flag.

Test Plan:
1. MSB=8, LOAD 0xA5 -> rsp_valid 9 cycles after accept, rsp_data=0xA5, sr_en high for exactly 8 cycles.
2. After LOAD 0xA5, ROTATE dir=0 count=3 -> rsp_data=0xB4, rsp_carry=1.
3. After LOAD 0x81, SHIFT dir=1 count=2 fill=0 -> rsp_data=0x04, rsp_carry=0. Then SHIFT dir=0 count=8 fill=1 -> rsp_data=0xFF.
4. SHIFT count=0 -> rsp_valid next cycle, rsp_data unchanged, sr_en never high. CLEAR -> sr_rstn low for 1 cycle, rsp_data=0x00.
5. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, no shifts occur.
6. Assert rst during RUN of a LOAD -> next cycle all outputs at reset values, cmd_ready=1, no rsp_valid pulse.
